cdc_event_scheduler: RTL and testbench
======================================

// Module: cdc_event_scheduler
// PURPOSE
//  Send-domain scheduler that shares one 4-phase request/ack CDC channel between NUM_REQ event sources.
//  Latches per-source events, round-robin arbitrates, presents source ID on out_id, then raises out_req.
//  Waits for the returned ack (synchronised internally) to rise and fall before serving the next source.
//  Sits in the fast/send domain in front of the receive-domain request synchroniser; out_id is bundled data.
// PARAMETERS
//  NUM_REQ       4  number of event sources (2..16)
//  ID_W          $clog2(NUM_REQ)  width of out_id (localparam, derived)
//  SYNC_STAGES   2  flops in the in_ack synchroniser (>=2)
//  SETUP_CYCLES  1  cycles out_id is stable before out_req rises (>=1)
// PORTS
//  in_clk        in   1        single clock; all logic on posedge
//  in_reset_n    in   1        asynchronous, active-low reset
//  in_evt        in   NUM_REQ  event requests; each sampled-high cycle marks source pending
//  in_ack        in   1        level ack from receive domain (asynchronous to in_clk)
//  out_req       out  1        level request to receive domain (registered, glitch-free)
//  out_id        out  ID_W     granted source index; stable from grant until return to IDLE
//  out_busy      out  1        1 whenever FSM != IDLE
//  out_done      out  1        1-cycle pulse when handshake for out_id completes
//  out_pending   out  NUM_REQ  current pending flags
//  out_ovf       out  NUM_REQ  sticky overflow flags (CDC_SCHED_OVF_EN only, else tied 0)
//  in_ovf_clr    in   1        clears out_ovf (CDC_SCHED_OVF_EN only, else ignored)
// BEHAVIOUR
//  Reset: all outputs 0, pending=0, rr pointer=NUM_REQ-1 (so source 0 wins first), FSM=IDLE, sync flops 0.
//  Pending: pending[i] <= 1 on in_evt[i]; cleared on grant of i; same-cycle set and clear of i -> set wins.
//  Repeated events while pending coalesce into one transfer.
//  Arbiter: round-robin, search from last_grant+1 with wrap to 0; only pending sources eligible.
//  FSM states and transitions:
//   IDLE    : any pending -> load out_id=winner, clear its pending, cnt=SETUP_CYCLES-1, -> SETUP
//   SETUP   : cnt==0 -> out_req<=1, -> REQ; else cnt--
//   REQ     : ack_s==1 -> out_req<=0, -> RELEASE
//   RELEASE : ack_s==0 -> out_done<=1 (one cycle), -> IDLE
//  ack_s = in_ack after SYNC_STAGES flops; no other path from in_ack to logic.
//  Latency: pending set at edge N -> grant at N+1 -> out_req high after edge N+1+SETUP_CYCLES.
//  Back-to-back: IDLE->SETUP of next source on edge after out_done; out_req low >= SETUP_CYCLES+1 cycles.
//  out_id never changes while out_req=1 or ack_s=1.
//  ack_s high in IDLE/SETUP (stale ack): hold in SETUP until ack_s==0 before raising out_req.
//  Reset mid-operation: immediate async clear, out_req drops; receive side is reset alongside.
// CONFIGURATION
//  CDC_SCHED_OVF_EN defined: out_ovf[i] set when in_evt[i]=1 while pending[i]=1 already,
//   or while i is granted and FSM!=IDLE; sticky until in_ovf_clr (clr and set same cycle -> set wins).
//  Undefined: overflow logic absent, out_ovf=0, in_ovf_clr unused; events coalesce silently.
// STRUCTURE
//  Package cdc_sched_pkg: FSM state enum (IDLE/SETUP/REQ/RELEASE, 2-bit), default parameter constants.
//  Sub-module cdc_sync_bit (SYNC_STAGES-flop, async active-low reset) for in_ack.
//  Arbiter, pending register, FSM and counters stay in this module.
// TESTING
//  1 in_evt=4'b0001 one cycle, ack model echoes req after 3 cycles -> out_id=0, out_req rises 2 edges after
//    pending set, single out_done, pending returns 0.
//  2 in_evt=4'b1111 one cycle -> grants served in order 0,1,2,3; exactly four out_done pulses.
//  3 Source 2 fires every cycle for 100 cycles with 1 and 3 also pending -> order 1,2,3,1,2,3...; no starvation.
//  4 in_ack forced high before any request -> out_req stays 0 until in_ack low + SYNC_STAGES cycles.
//  5 Assert in_reset_n low while in REQ -> all outputs 0 asynchronously; after release first grant is source 0.
//  6 (CDC_SCHED_OVF_EN) in_evt[1] twice while pending[1]=1 -> out_ovf=4'b0010 until in_ovf_clr; without macro out_ovf=0.

Source files
------------

// File: rtl/cdc_sched_pkg.sv
// Shared types and default parameter values for the CDC event scheduler.
// The FSM encoding is fixed at 2 bits.
package cdc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_REQ     = 2'd2,
      ST_RELEASE = 2'd3
   } sched_state_e;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_SETUP_CYCLES = 1;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop level synchroniser for a single asynchronous bit.
// Latency STAGES cycles; no handshake, the input is a slow level.
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_event_scheduler.sv
// Round-robin scheduler sharing one 4-phase req/ack CDC channel between NUM_REQ sources;
// grant one cycle after pending, out_req SETUP_CYCLES later; optional overflow flags via CDC_SCHED_OVF_EN.
module cdc_event_scheduler
   import cdc_sched_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
   input  logic                       in_clk,
   input  logic                       in_reset_n,
   input  logic [NUM_REQ-1:0]         in_evt,
   input  logic                       in_ack,
   input  logic                       in_ovf_clr,
   output logic                       out_req,
   output logic [$clog2(NUM_REQ)-1:0] out_id,
   output logic                       out_busy,
   output logic                       out_done,
   output logic [NUM_REQ-1:0]         out_pending,
   output logic [NUM_REQ-1:0]         out_ovf
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

   sched_state_e       state_q, state_d;
   logic [NUM_REQ-1:0] pend_q, pend_d, grant_clr;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               req_q, req_d;
   logic               done_q, done_d;
   logic               ack_s;
   logic [ID_W-1:0]    win;
   logic               any_pend;

   cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk_i  (in_clk),
      .rst_ni (in_reset_n),
      .d_i    (in_ack),
      .q_o    (ack_s)
   );

   // Walk from farthest to nearest so the source right after rr_q wins.
   always_comb begin
      logic [ID_W-1:0] cand;
      win      = '0;
      any_pend = 1'b0;
      cand     = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
         if (pend_q[cand]) begin
            win      = cand;
            any_pend = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      done_d    = 1'b0;
      grant_clr = '0;
      case (state_q)
         ST_IDLE: begin
            if (any_pend) begin
               id_d           = win;
               rr_d           = win;
               grant_clr[win] = 1'b1;
               cnt_d          = CNT_W'(SETUP_CYCLES - 1);
               state_d        = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // A stale ack from the previous transfer must clear before a new request.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!ack_s) begin
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pend_d = (pend_q & ~grant_clr) | in_evt;

   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         id_q    <= '0;
         rr_q    <= ID_W'(NUM_REQ - 1);
         cnt_q   <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         done_q  <= done_d;
      end
   end

`ifdef CDC_SCHED_OVF_EN
   logic [NUM_REQ-1:0] ovf_q, ovf_d, ovf_set, owner;

   always_comb begin
      owner = '0;
      if (state_q != ST_IDLE) begin
         owner[id_q] = 1'b1;
      end
      ovf_set = in_evt & (pend_q | owner);
      ovf_d   = ovf_set | (in_ovf_clr ? '0 : ovf_q);
   end

   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign out_ovf = ovf_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = in_ovf_clr;
   assign out_ovf        = '0;
`endif

   assign out_req     = req_q;
   assign out_id      = id_q;
   assign out_busy    = (state_q != ST_IDLE);
   assign out_done    = done_q;
   assign out_pending = pend_q;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Directed and randomized bench for cdc_event_scheduler with a set-based round-robin reference model.
// Overflow expectations follow CDC_SCHED_OVF_EN when it is defined.
module tb_cdc_event_scheduler;

   localparam int NUM_REQ     = 4;
   localparam int SYNC_STAGES = 2;

`ifdef CDC_SCHED_OVF_EN
   localparam logic [3:0] EXP_OVF = 4'b0010;
`else
   localparam logic [3:0] EXP_OVF = 4'b0000;
`endif

   logic       in_clk     = 1'b0;
   logic       in_reset_n = 1'b0;
   logic [3:0] in_evt     = '0;
   logic       in_ovf_clr = 1'b0;
   logic       in_ack;
   logic       out_req;
   logic [1:0] out_id;
   logic       out_busy;
   logic       out_done;
   logic [3:0] out_pending;
   logic [3:0] out_ovf;

   cdc_event_scheduler #(.NUM_REQ(4), .SYNC_STAGES(2), .SETUP_CYCLES(1)) dut (
      .in_clk      (in_clk),
      .in_reset_n  (in_reset_n),
      .in_evt      (in_evt),
      .in_ack      (in_ack),
      .in_ovf_clr  (in_ovf_clr),
      .out_req     (out_req),
      .out_id      (out_id),
      .out_busy    (out_busy),
      .out_done    (out_done),
      .out_pending (out_pending),
      .out_ovf     (out_ovf)
   );

   always #5 in_clk = ~in_clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Receive side: echoes out_req three cycles later, or holds ack high when forced.
   logic [2:0] ack_hist = '0;
   logic       ack_force = 1'b0;
   always @(negedge in_clk) begin
      if (!in_reset_n) ack_hist = '0;
      else             ack_hist = {ack_hist[1:0], out_req};
   end
   assign in_ack = ack_force | ack_hist[2];

   // Reference model: pending set plus last grant, next winner by plain round-robin search.
   function automatic int rr_pick(input logic [3:0] p, input int last);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (p[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
      end
      return -1;
   endfunction

   logic [3:0] evt_at_edge = '0;
   always @(posedge in_clk) evt_at_edge <= in_evt;

   logic [3:0] m_pend = '0;
   int         m_last = NUM_REQ - 1;
   int         w;
   int         grant_q[$];
   int         done_cnt = 0;
   logic       prev_busy = 1'b0, prev_req = 1'b0, prev_done = 1'b0;
   logic [1:0] prev_id = '0;

   always @(negedge in_clk) begin
      if (!in_reset_n) begin
         m_pend    = '0;
         m_last    = NUM_REQ - 1;
         prev_busy = 1'b0;
         prev_req  = 1'b0;
         prev_done = 1'b0;
      end else begin
         if (out_busy && !prev_busy) begin
            w = rr_pick(m_pend, m_last);
            check("grant_id", 32'(out_id), 32'(w));
            if (w >= 0) begin
               m_pend[w] = 1'b0;
               m_last    = w;
            end
            grant_q.push_back(int'(out_id));
         end
         m_pend = m_pend | evt_at_edge;
         check("pending", 32'(out_pending), 32'(m_pend));
         if (prev_req && out_req) check("id_stable", 32'(out_id), 32'(prev_id));
         if (out_done) begin
            done_cnt++;
            check("done_single", 32'(prev_done), 32'(0));
         end
`ifndef CDC_SCHED_OVF_EN
         check("ovf_zero", 32'(out_ovf), 32'(0));
`endif
         prev_busy = out_busy;
         prev_req  = out_req;
         prev_id   = out_id;
         prev_done = out_done;
      end
   end

   task automatic pulse(input logic [3:0] v);
      @(negedge in_clk) in_evt = v;
      @(negedge in_clk) in_evt = '0;
   endtask

   task automatic do_reset();
      @(negedge in_clk);
      #2 in_reset_n = 1'b0;
      repeat (2) @(negedge in_clk);
      #2 in_reset_n = 1'b1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((out_busy || out_pending != '0) && n < budget) begin
         @(negedge in_clk);
         n++;
      end
      check({tag, "_drain"}, 32'(n < budget), 32'(1));
      @(negedge in_clk);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (!out_req && n < budget) begin
         @(negedge in_clk);
         n++;
      end
      check({tag, "_req_seen"}, 32'(n < budget), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0, d0, n;

      // Reset state
      repeat (2) @(negedge in_clk);
      check("rst_req", 32'(out_req), 32'(0));
      check("rst_id", 32'(out_id), 32'(0));
      check("rst_busy", 32'(out_busy), 32'(0));
      check("rst_done", 32'(out_done), 32'(0));
      check("rst_pend", 32'(out_pending), 32'(0));
      check("rst_ovf", 32'(out_ovf), 32'(0));
      #2 in_reset_n = 1'b1;

      // 1: single event, exact latency
      d0 = done_cnt;
      @(negedge in_clk) in_evt = 4'b0001;
      @(negedge in_clk) in_evt = '0;
      check("t1_pend_set", 32'(out_pending), 32'(4'b0001));
      check("t1_idle", 32'(out_busy), 32'(0));
      @(negedge in_clk);
      check("t1_grant_id", 32'(out_id), 32'(0));
      check("t1_busy", 32'(out_busy), 32'(1));
      check("t1_req_low", 32'(out_req), 32'(0));
      check("t1_pend_clr", 32'(out_pending), 32'(0));
      @(negedge in_clk);
      check("t1_req_high", 32'(out_req), 32'(1));
      wait_drain("t1", 100);
      check("t1_done_cnt", 32'(done_cnt - d0), 32'(1));
      check("t1_pend_end", 32'(out_pending), 32'(0));

      // 2: all four at once, served 0..3
      do_reset();
      g0 = grant_q.size();
      d0 = done_cnt;
      pulse(4'b1111);
      wait_drain("t2", 300);
      check("t2_grants", 32'(grant_q.size() - g0), 32'(4));
      check("t2_dones", 32'(done_cnt - d0), 32'(4));
      for (int k = 0; k < 4 && g0 + k < grant_q.size(); k++)
         check("t2_order", 32'(grant_q[g0 + k]), 32'(k));

      // 3: 1,2,3 refire every cycle for 100 cycles
      g0 = grant_q.size();
      repeat (100) begin
         @(negedge in_clk) in_evt = 4'b1110;
      end
      @(negedge in_clk) in_evt = '0;
      wait_drain("t3", 300);
      n = grant_q.size() - g0;
      check("t3_enough", 32'(n >= 6), 32'(1));
      for (int k = 0; k < n; k++)
         check("t3_order", 32'(grant_q[g0 + k]), 32'(1 + (k % 3)));

      // 4: stale ack holds the request back
      @(negedge in_clk) ack_force = 1'b1;
      repeat (4) @(negedge in_clk);
      pulse(4'b0001);
      repeat (8) begin
         @(negedge in_clk);
         check("t4_req_hold", 32'(out_req), 32'(0));
      end
      check("t4_busy", 32'(out_busy), 32'(1));
      ack_force = 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
         @(negedge in_clk);
         check("t4_req_sync", 32'(out_req), 32'(0));
      end
      @(negedge in_clk);
      check("t4_req_rise", 32'(out_req), 32'(1));
      wait_drain("t4", 100);

      // 5: async reset during REQ
      pulse(4'b0100);
      wait_req("t5", 50);
      @(posedge in_clk);
      #3 in_reset_n = 1'b0;
      #1;
      check("t5_req", 32'(out_req), 32'(0));
      check("t5_busy", 32'(out_busy), 32'(0));
      check("t5_id", 32'(out_id), 32'(0));
      check("t5_done", 32'(out_done), 32'(0));
      check("t5_pend", 32'(out_pending), 32'(0));
      check("t5_ovf", 32'(out_ovf), 32'(0));
      repeat (2) @(negedge in_clk);
      #2 in_reset_n = 1'b1;
      g0 = grant_q.size();
      pulse(4'b1001);
      n = 0;
      while (grant_q.size() == g0 && n < 20) begin
         @(negedge in_clk);
         n++;
      end
      check("t5_grant_seen", 32'(n < 20), 32'(1));
      if (grant_q.size() > g0) check("t5_first", 32'(grant_q[g0]), 32'(0));
      wait_drain("t5", 200);

      // 6: overflow on repeated event while pending
      @(negedge in_clk) in_ovf_clr = 1'b1;
      @(negedge in_clk) in_ovf_clr = 1'b0;
      check("t6_ovf_clean", 32'(out_ovf), 32'(0));
      @(negedge in_clk) in_evt = 4'b0001;
      @(negedge in_clk) in_evt = 4'b0010;
      @(negedge in_clk) in_evt = 4'b0010;
      @(negedge in_clk) in_evt = '0;
      check("t6_ovf_set", 32'(out_ovf), 32'(EXP_OVF));
      repeat (5) @(negedge in_clk);
      check("t6_ovf_sticky", 32'(out_ovf), 32'(EXP_OVF));
      @(negedge in_clk) in_ovf_clr = 1'b1;
      @(negedge in_clk) in_ovf_clr = 1'b0;
      check("t6_ovf_clr", 32'(out_ovf), 32'(0));
      wait_drain("t6", 200);

      // Randomized traffic against the model
      g0 = grant_q.size();
      d0 = done_cnt;
      repeat (400) begin
         @(negedge in_clk) in_evt = 4'($urandom) & 4'($urandom);
      end
      @(negedge in_clk) in_evt = '0;
      wait_drain("rnd", 400);
      check("rnd_some", 32'(grant_q.size() - g0 > 0), 32'(1));
      check("rnd_done_match", 32'(done_cnt - d0), 32'(grant_q.size() - g0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
